// File: rtl/engine_arbiter_pkg.sv
// +----------------------------------------------------------------------+
// | engine_arbiter_pkg : shared types, defaults and arbitration helper   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package engine_arbiter_pkg;

  localparam int FRAME_LEN_DEF = 6;
  localparam int MIN_GAP_DEF   = 2;
  localparam int TIMEOUT_DEF   = 2000;
  localparam int DATA_W        = 9;
  localparam int MODE_W        = 3;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [MODE_W-1:0] mode_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEND  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

  // On a tie the port that was not served last wins.
  function automatic port_t rr_pick(input logic a_req, input logic b_req, input port_t last);
    if (a_req && b_req) begin
      return (last == PORT_A) ? PORT_B : PORT_A;
    end else if (b_req) begin
      return PORT_B;
    end
    return PORT_A;
  endfunction

endpackage

`default_nettype wire

// File: rtl/engine_arbiter_frame_buf.sv
// +----------------------------------------------------------------------+
// | engine_arbiter_frame_buf : one-frame capture buffer with read port   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module engine_arbiter_frame_buf
  import engine_arbiter_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int IDX_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_in_data,
  input  logic [MODE_W-1:0] i_in_mode,
  input  logic              i_free,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic [DATA_W-1:0] o_rd_data,
  output logic [MODE_W-1:0] o_mode,
  output logic              o_busy
);

  logic [IDX_W-1:0] r_wr_idx;
  data_t            r_mem [FRAME_LEN];
  mode_t            r_mode;
  logic             r_busy;
  logic             w_wr_en;

  // A full buffer ignores further input until the arbiter frees it.
  assign w_wr_en = i_in_valid && !r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_idx <= '0;
      r_mode   <= '0;
      r_busy   <= 1'b0;
      for (int i = 0; i < FRAME_LEN; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr_idx] <= i_in_data;
        if (r_wr_idx == '0) begin
          r_mode <= i_in_mode;
        end
        if (r_wr_idx == IDX_W'(FRAME_LEN - 1)) begin
          r_wr_idx <= '0;
          r_busy   <= 1'b1;
        end else begin
          r_wr_idx <= r_wr_idx + IDX_W'(1);
        end
      end else if (i_free) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_rd_data = r_mem[i_rd_idx];
  assign o_mode    = r_mode;
  assign o_busy    = r_busy;

endmodule

`default_nettype wire

// File: rtl/engine_arbiter.sv
// +----------------------------------------------------------------------+
// | engine_arbiter : round-robin sharing of one engine between A and B   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module engine_arbiter
  import engine_arbiter_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int MIN_GAP   = MIN_GAP_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_a_in_valid,
  input  logic [DATA_W-1:0] i_a_in_data,
  input  logic [MODE_W-1:0] i_a_in_mode,
  input  logic              i_b_in_valid,
  input  logic [DATA_W-1:0] i_b_in_data,
  input  logic [MODE_W-1:0] i_b_in_mode,
  output logic              o_a_busy,
  output logic              o_b_busy,
  output logic              o_eng_in_valid,
  output logic [DATA_W-1:0] o_eng_in_data,
  output logic [MODE_W-1:0] o_eng_in_mode,
  input  logic              i_eng_out_valid,
  input  logic [DATA_W-1:0] i_eng_out_data,
  output logic              o_out_valid,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_id,
  output logic              o_err_timeout
);

  localparam int IDX_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int CNT_MAX  = (TIMEOUT > FRAME_LEN) ? ((TIMEOUT > MIN_GAP) ? TIMEOUT : MIN_GAP)
                                                  : ((FRAME_LEN > MIN_GAP) ? FRAME_LEN : MIN_GAP);
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int GAP_LAST = (MIN_GAP > 0) ? MIN_GAP - 1 : 0;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  port_t            r_grant;
  port_t            w_grant_nxt;
  port_t            r_last;
  port_t            w_last_nxt;

  logic             w_timeout;
  logic             w_free;
  logic             w_accept;
  logic             w_out_take;
  logic             w_send;

  logic             w_a_busy;
  logic             w_b_busy;
  logic [DATA_W-1:0] w_a_rd_data;
  logic [DATA_W-1:0] w_b_rd_data;
  logic [MODE_W-1:0] w_a_mode;
  logic [MODE_W-1:0] w_b_mode;
  logic [DATA_W-1:0] w_sel_data;
  logic [MODE_W-1:0] w_sel_mode;
  logic [IDX_W-1:0]  w_rd_idx;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_id;

  assign w_rd_idx = r_cnt[IDX_W-1:0];

  engine_arbiter_frame_buf #(
    .FRAME_LEN (FRAME_LEN),
    .IDX_W     (IDX_W)
  ) u_buf_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_in_valid(i_a_in_valid),
    .i_in_data (i_a_in_data),
    .i_in_mode (i_a_in_mode),
    .i_free    (w_free && (r_grant == PORT_A)),
    .i_rd_idx  (w_rd_idx),
    .o_rd_data (w_a_rd_data),
    .o_mode    (w_a_mode),
    .o_busy    (w_a_busy)
  );

  engine_arbiter_frame_buf #(
    .FRAME_LEN (FRAME_LEN),
    .IDX_W     (IDX_W)
  ) u_buf_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_in_valid(i_b_in_valid),
    .i_in_data (i_b_in_data),
    .i_in_mode (i_b_in_mode),
    .i_free    (w_free && (r_grant == PORT_B)),
    .i_rd_idx  (w_rd_idx),
    .o_rd_data (w_b_rd_data),
    .o_mode    (w_b_mode),
    .o_busy    (w_b_busy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_grant <= PORT_A;
      r_last  <= PORT_B;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // r_cnt is shared: word index in SEND, wait length in WAIT, idle length in GAP.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_timeout   = 1'b0;
    w_free      = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_a_busy || w_b_busy) begin
          w_grant_nxt = rr_pick(w_a_busy, w_b_busy, r_last);
          w_last_nxt  = w_grant_nxt;
          w_state_nxt = ST_SEND;
          w_cnt_nxt   = '0;
        end
      end
      ST_SEND: begin
        if (r_cnt == CNT_W'(FRAME_LEN - 1)) begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_WAIT: begin
        w_accept = 1'b1;
        if (i_eng_out_valid) begin
          w_state_nxt = ST_DRAIN;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_timeout   = 1'b1;
          w_free      = 1'b1;
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        w_accept = 1'b1;
        if (!i_eng_out_valid) begin
          w_free      = 1'b1;
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = '0;
        end
      end
      ST_GAP: begin
        if (r_cnt >= CNT_W'(GAP_LAST)) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_out_take = w_accept && i_eng_out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_id    <= 1'b0;
    end else begin
      r_out_valid <= w_out_take;
      r_out_data  <= w_out_take ? i_eng_out_data : '0;
      r_out_id    <= w_out_take ? logic'(r_grant) : 1'b0;
    end
  end

  assign w_send     = (r_state == ST_SEND);
  assign w_sel_data = (r_grant == PORT_B) ? w_b_rd_data : w_a_rd_data;
  assign w_sel_mode = (r_grant == PORT_B) ? w_b_mode : w_a_mode;

  assign o_eng_in_valid = w_send;
  assign o_eng_in_data  = w_send ? w_sel_data : '0;
  assign o_eng_in_mode  = (w_send && (r_cnt == '0)) ? w_sel_mode : '0;
  assign o_out_valid    = r_out_valid;
  assign o_out_data     = r_out_data;
  assign o_out_id       = r_out_id;
  assign o_err_timeout  = w_timeout;
  assign o_a_busy       = w_a_busy;
  assign o_b_busy       = w_b_busy;

endmodule

`default_nettype wire

// File: tb/tb_engine_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_engine_arbiter : scoreboard bench for engine_arbiter              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_engine_arbiter;

  localparam int FL = 6;
  localparam int TO = 2000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_in_valid = 1'b0, b_in_valid = 1'b0;
  logic [8:0] a_in_data = '0, b_in_data = '0;
  logic [2:0] a_in_mode = '0, b_in_mode = '0;
  logic       a_busy, b_busy;
  logic       eng_in_valid;
  logic [8:0] eng_in_data;
  logic [2:0] eng_in_mode;
  logic       eng_out_valid = 1'b0;
  logic [8:0] eng_out_data = '0;
  logic       out_valid;
  logic [8:0] out_data;
  logic       out_id;
  logic       err_timeout;

  engine_arbiter #(.FRAME_LEN(FL), .MIN_GAP(2), .TIMEOUT(TO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_a_in_valid   (a_in_valid),
    .i_a_in_data    (a_in_data),
    .i_a_in_mode    (a_in_mode),
    .i_b_in_valid   (b_in_valid),
    .i_b_in_data    (b_in_data),
    .i_b_in_mode    (b_in_mode),
    .o_a_busy       (a_busy),
    .o_b_busy       (b_busy),
    .o_eng_in_valid (eng_in_valid),
    .o_eng_in_data  (eng_in_data),
    .o_eng_in_mode  (eng_in_mode),
    .i_eng_out_valid(eng_out_valid),
    .i_eng_out_data (eng_out_data),
    .o_out_valid    (out_valid),
    .o_out_data     (out_data),
    .o_out_id       (out_id),
    .o_err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct { int data; int mode; } in_exp_t;
  typedef struct { int data; int id; int cyc; } out_exp_t;
  in_exp_t  q_in[$];
  out_exp_t q_out[$];
  int       q_to[$];
  in_exp_t  m_in;
  out_exp_t m_out;
  int       m_to;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: pops an expectation whenever the DUT presents something.
  always @(negedge clk) begin
    if (rst_n) begin
      if (eng_in_valid) begin
        if (q_in.size() == 0) chk("eng_in_unexpected", q_in.size(), 1);
        else begin
          m_in = q_in.pop_front();
          chk("eng_in_data", eng_in_data, m_in.data);
          chk("eng_in_mode", eng_in_mode, m_in.mode);
        end
      end else begin
        chk("eng_in_idle_data", eng_in_data, 0);
        chk("eng_in_idle_mode", eng_in_mode, 0);
      end
      if (out_valid) begin
        if (q_out.size() == 0) chk("out_unexpected", q_out.size(), 1);
        else begin
          m_out = q_out.pop_front();
          chk("out_data", out_data, m_out.data);
          chk("out_id", out_id, m_out.id);
          chk("out_cycle", cyc, m_out.cyc);
        end
      end else begin
        chk("out_idle_data", out_data, 0);
        chk("out_idle_id", out_id, 0);
      end
      if (err_timeout) begin
        if (q_to.size() == 0) chk("timeout_unexpected", q_to.size(), 1);
        else begin
          m_to = q_to.pop_front();
          chk("timeout_cycle", cyc, m_to);
        end
      end
    end
  end

  task automatic push_in(input int base, input int mode);
    for (int i = 0; i < FL; i++) q_in.push_back('{base + i, (i == 0) ? mode : 0});
  endtask

  // Drives from the current cycle; mode lines carry junk after word 0.
  task automatic drive_frames(input bit da, input int ba, input int ma,
                              input bit db, input int bb, input int mb);
    for (int i = 0; i < FL; i++) begin
      a_in_valid = da;
      a_in_data  = da ? 9'(ba + i) : 9'd0;
      a_in_mode  = (i == 0) ? 3'(ma) : 3'd7;
      b_in_valid = db;
      b_in_data  = db ? 9'(bb + i) : 9'd0;
      b_in_mode  = (i == 0) ? 3'(mb) : 3'd7;
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0; a_in_data = '0; a_in_mode = '0;
    b_in_valid = 1'b0; b_in_data = '0; b_in_mode = '0;
  endtask

  task automatic wait_send_start(output int c);
    c = -1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (eng_in_valid) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) chk("send_start_bound", eng_in_valid, 1);
  endtask

  task automatic wait_send_done(output int w);
    int c;
    wait_send_start(c);
    w = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!eng_in_valid) begin
        w = cyc;
        break;
      end
    end
    if (w < 0) chk("send_end_bound", eng_in_valid, 0);
  endtask

  task automatic engine_burst(input int n, input int base, input int id, output int last);
    last = cyc;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      eng_out_valid = 1'b1;
      eng_out_data  = 9'(base + i);
      q_out.push_back('{base + i, id, cyc + 1});
      last = cyc;
    end
    @(posedge clk); #1;
    eng_out_valid = 1'b0;
    eng_out_data  = '0;
  endtask

  task automatic serve(input int id, input int base, input int n, output int last);
    int w;
    wait_send_done(w);
    engine_burst(n, base, id, last);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int d, c, w;
    idle(3);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_eng_in_valid", eng_in_valid, 0);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_b_busy", b_busy, 0);
    chk("rst_err_timeout", err_timeout, 0);
    idle(1);

    // Basic A frame, 6-word engine burst.
    push_in(1, 3);
    drive_frames(1, 1, 3, 0, 0, 0);
    chk("a_busy_after_frame", a_busy, 1);
    serve(0, 'h50, 6, d);
    idle(3);
    chk("a_busy_after_drain", a_busy, 0);

    // Stray engine output while idle must be dropped.
    eng_out_valid = 1'b1; eng_out_data = 9'h1ff;
    idle(2);
    eng_out_valid = 1'b0; eng_out_data = '0;
    idle(3);

    // B frame, then a second B frame while busy that must be ignored.
    push_in('h20, 5);
    drive_frames(0, 0, 0, 1, 'h20, 5);
    drive_frames(0, 0, 0, 1, 'h40, 1);
    chk("b_busy_held", b_busy, 1);
    serve(1, 'h80, 3, d);
    idle(3);
    chk("b_busy_after_drain", b_busy, 0);
    idle(4);

    // Engine silent: timeout, buffer freed, new frame accepted as busy falls.
    push_in('h30, 2);
    drive_frames(1, 'h30, 2, 0, 0, 0);
    wait_send_done(w);
    q_to.push_back(w + TO - 1);
    while (cyc < w + TO - 1) @(negedge clk);
    chk("a_busy_at_timeout", a_busy, 1);
    @(posedge clk); #1;
    chk("a_busy_after_timeout", a_busy, 0);
    push_in('h60, 4);
    drive_frames(1, 'h60, 4, 0, 0, 0);
    wait_send_start(c);
    chk("resend_after_gap_cycle", c, w + TO + 7);
    serve(0, 'hc0, 2, d);
    idle(5);

    // Reset in the middle of a drain burst.
    push_in('h70, 1);
    drive_frames(1, 'h70, 1, 0, 0, 0);
    wait_send_done(w);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      eng_out_valid = 1'b1;
      eng_out_data  = 9'('h90 + i);
      q_out.push_back('{'h90 + i, 0, cyc + 1});
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_a_busy", a_busy, 0);
    eng_out_valid = 1'b0; eng_out_data = '0;
    q_in.delete(); q_out.delete(); q_to.delete();
    idle(2);
    rst_n = 1'b1;
    idle(1);
    push_in('h90, 6);
    drive_frames(0, 0, 0, 1, 'h90, 6);
    serve(1, 'h10, 4, d);
    idle(3);
    chk("b_busy_after_rst_frame", b_busy, 0);
    idle(3);

    // Tie: A first, B after A's drain plus two gap cycles.
    push_in('h100, 1);
    push_in('h110, 2);
    drive_frames(1, 'h100, 1, 1, 'h110, 2);
    serve(0, 'h20, 3, d);
    wait_send_start(c);
    chk("tie_b_start_cycle", c, d + 5);
    serve(1, 'h30, 2, d);
    idle(6);

    // Next tie goes to A again.
    push_in('h120, 3);
    push_in('h130, 4);
    drive_frames(1, 'h120, 3, 1, 'h130, 4);
    serve(0, 'h40, 1, d);
    serve(1, 'h48, 2, d);
    idle(6);

    // After A is served alone, a tie goes to B.
    push_in('h140, 5);
    drive_frames(1, 'h140, 5, 0, 0, 0);
    serve(0, 'h50, 1, d);
    idle(6);
    push_in('h160, 7);
    push_in('h150, 6);
    drive_frames(1, 'h150, 6, 1, 'h160, 7);
    serve(1, 'h58, 2, d);
    serve(0, 'h60, 2, d);
    idle(10);

    chk("q_in_empty", q_in.size(), 0);
    chk("q_out_empty", q_out.size(), 0);
    chk("q_to_empty", q_to.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
